// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: IRQ/mask/enable/hold/eret inputs and take/vector/status outputs.
// Latency: none, wires only.
// Backpressure: none here; in_HOLD carries the pipeline stall into the controller.
interface int_ctrl_if;
  logic [2:0]  in_IRQ;
  logic        in_IE;
  logic [3:0]  in_INM;
  logic        in_HOLD;
  logic        in_eret;
  logic        out_BK;
  logic        out_NIE;
  logic [1:0]  out_code;
  logic [31:0] out_VEC;
  logic [2:0]  out_PEND;
  logic        out_BUSY;
  logic [7:0]  out_CNT;

  // Pipeline / CP0 side: drives requests and control, observes the controller.
  modport master (
    output in_IRQ, in_IE, in_INM, in_HOLD, in_eret,
    input  out_BK, out_NIE, out_code, out_VEC, out_PEND, out_BUSY, out_CNT
  );

  // Controller side.
  modport slave (
    input  in_IRQ, in_IE, in_INM, in_HOLD, in_eret,
    output out_BK, out_NIE, out_code, out_VEC, out_PEND, out_BUSY, out_CNT
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects 3 sources, fixed priority 3>2>1, one non-nested service at a time.
// Latency: an IRQ rising edge pends on the next clock; ACK follows one clock later when eligible.
// Backpressure: in_HOLD stalls the IDLE->ACK step; requests stay pending until taken.
module int_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 5
) (
  input logic       in_CLK,
  input logic       in_RST,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_SERVICE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  irq_q, irq_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  rise;
  logic [2:0]  elig;
  logic [2:0]  clr;
  logic [1:0]  pick;

  // Mask bit 0 has no source behind it.
  logic unused_inm0;
  assign unused_inm0 = bus.in_INM[0];

  // Edge detect, eligibility and fixed-priority pick (source 3 wins).
  always_comb begin
    irq_d = bus.in_IRQ;
    rise  = bus.in_IRQ & ~irq_q;
    elig  = pend_q & ~bus.in_INM[3:1] & {3{bus.in_IE}};
    pick  = 2'd0;
    if (elig[2]) begin
      pick = 2'd3;
    end else if (elig[1]) begin
      pick = 2'd2;
    end else if (elig[0]) begin
      pick = 2'd1;
    end
  end

  // Next state, latched code, take counter and pending update (a new edge beats the clear).
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    clr     = 3'b000;
    case (state_q)
      S_IDLE: begin
        if ((pick != 2'd0) && !bus.in_HOLD) begin
          state_d = S_ACK;
          code_d  = pick;
        end
      end
      S_ACK: begin
        state_d = S_SERVICE;
        cnt_d   = cnt_q + 8'd1;
        clr     = 3'b001 << (code_q - 2'd1);
      end
      S_SERVICE: begin
        if (bus.in_eret) begin
          state_d = S_DRAIN;
          code_d  = 2'd0;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        code_d  = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        code_d  = 2'd0;
      end
    endcase
    pend_d = (pend_q & ~clr) | rise;
  end

  // State registers; reset abandons any service in progress.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q <= S_IDLE;
      irq_q   <= 3'b000;
      pend_q  <= 3'b000;
      code_q  <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are registers or state decodes; only the vector is combinational from the code.
  assign bus.out_BK   = (state_q == S_ACK);
  assign bus.out_NIE  = (state_q != S_ACK);
  assign bus.out_BUSY = (state_q == S_ACK) || (state_q == S_SERVICE);
  assign bus.out_code = code_q;
  assign bus.out_PEND = pend_q;
  assign bus.out_CNT  = cnt_q;
  assign bus.out_VEC  = VEC_BASE + ({30'd0, code_q} << VEC_STRIDE);

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: vector table, hand-written corner sequences, randomized run against a model.
// Latency: outputs sampled 1ns after each rising clock edge.
// Backpressure: in_HOLD driven directly by the stimulus.
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int_ctrl_if bus();

  int_ctrl #(.VEC_BASE(32'h0000_0100), .VEC_STRIDE(5)) dut (
    .in_CLK(clk),
    .in_RST(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bk;
    logic        nie;
    logic [1:0]  code;
    logic [31:0] vec;
    logic [2:0]  pend;
    logic        busy;
    logic [7:0]  cnt;
  } obs_t;

  typedef struct {
    logic [2:0] irq;
    logic [3:0] inm;
    logic       hold;
    logic       eret;
    obs_t       exp;
  } row_t;

  row_t tbl[$];

  // Reference model state: service phase flags, pending set, last seen IRQ levels.
  bit m_pend [1:3];
  bit m_prev [1:3];
  int m_code;
  bit m_ack, m_svc, m_drain;
  int m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t snap();
    obs_t o;
    o.bk   = bus.out_BK;
    o.nie  = bus.out_NIE;
    o.code = bus.out_code;
    o.vec  = bus.out_VEC;
    o.pend = bus.out_PEND;
    o.busy = bus.out_BUSY;
    o.cnt  = bus.out_CNT;
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t g, input obs_t e);
    chk({tag, ".bk"},   32'(g.bk),   32'(e.bk));
    chk({tag, ".nie"},  32'(g.nie),  32'(e.nie));
    chk({tag, ".code"}, 32'(g.code), 32'(e.code));
    chk({tag, ".vec"},  g.vec,       e.vec);
    chk({tag, ".pend"}, 32'(g.pend), 32'(e.pend));
    chk({tag, ".busy"}, 32'(g.busy), 32'(e.busy));
    chk({tag, ".cnt"},  32'(g.cnt),  32'(e.cnt));
  endtask

  function automatic row_t mk(input logic [2:0] irq, input logic [3:0] inm, input logic hold,
                              input logic eret, input logic bk, input logic nie, input logic [1:0] code,
                              input logic [31:0] vec, input logic [2:0] pend, input logic busy,
                              input logic [7:0] cnt);
    row_t r;
    r.irq = irq; r.inm = inm; r.hold = hold; r.eret = eret;
    r.exp.bk = bk; r.exp.nie = nie; r.exp.code = code; r.exp.vec = vec;
    r.exp.pend = pend; r.exp.busy = busy; r.exp.cnt = cnt;
    return r;
  endfunction

  task automatic set_in(input logic [2:0] irq, input logic ie, input logic [3:0] inm,
                        input logic hold, input logic eret);
    bus.in_IRQ = irq; bus.in_IE = ie; bus.in_INM = inm; bus.in_HOLD = hold; bus.in_eret = eret;
  endtask

  task automatic reset_dut();
    set_in(3'b000, 1'b1, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From ACK: move to SERVICE, retire with eret, pass DRAIN, land in IDLE.
  task automatic finish_service();
    tick();
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    for (int s = 1; s <= 3; s++) begin
      m_pend[s] = 1'b0;
      m_prev[s] = 1'b0;
    end
    m_code = 0; m_ack = 0; m_svc = 0; m_drain = 0; m_cnt = 0;
  endtask

  // One clock of the model, given the inputs present before the edge.
  task automatic model_edge(input logic [2:0] irq, input logic ie, input logic [3:0] inm,
                            input logic hold, input logic eret);
    int pick;
    pick = 0;
    for (int s = 1; s <= 3; s++)
      if (m_pend[s] && !inm[s] && ie) pick = s;
    if (m_ack) begin
      m_pend[m_code] = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
      m_ack = 0;
      m_svc = 1;
    end else if (m_svc) begin
      if (eret) begin
        m_svc = 0;
        m_code = 0;
        m_drain = 1;
      end
    end else if (m_drain) begin
      m_drain = 0;
    end else if (pick != 0 && !hold) begin
      m_code = pick;
      m_ack = 1;
    end
    for (int s = 1; s <= 3; s++) begin
      if (irq[s-1] && !m_prev[s]) m_pend[s] = 1'b1;
      m_prev[s] = irq[s-1];
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bk   = m_ack;
    o.nie  = !m_ack;
    o.code = 2'(m_code);
    o.vec  = 32'h100 + 32'(m_code) * 32;
    o.pend = {m_pend[3], m_pend[2], m_pend[1]};
    o.busy = m_ack || m_svc;
    o.cnt  = 8'(m_cnt);
    return o;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       bk_seen;
    logic [2:0] r_irq;
    obs_t       rst_exp;

    set_in(3'b000, 1'b1, 4'h0, 1'b0, 1'b0);
    rst_exp = '{bk: 1'b0, nie: 1'b1, code: 2'd0, vec: 32'h100, pend: 3'b000, busy: 1'b0, cnt: 8'd0};
    #1 rst = 1'b1;
    #1 chk_obs("reset", snap(), rst_exp);
    tick();
    tick();
    rst = 1'b0;

    // Single IRQ, priority with hold-off, eret ignored outside SERVICE.
    //             irq     inm   hold  eret  bk nie code vec      pend   busy cnt
    tbl.push_back(mk(3'b001, 4'h0, 1'b0, 1'b0, 0, 1, 2'd0, 32'h100, 3'b001, 0, 8'd0));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 1, 0, 2'd1, 32'h120, 3'b001, 1, 8'd0));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 0, 1, 2'd1, 32'h120, 3'b000, 1, 8'd1));
    tbl.push_back(mk(3'b011, 4'h0, 1'b0, 1'b0, 0, 1, 2'd1, 32'h120, 3'b011, 1, 8'd1));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b1, 0, 1, 2'd0, 32'h100, 3'b011, 0, 8'd1));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 0, 1, 2'd0, 32'h100, 3'b011, 0, 8'd1));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 1, 0, 2'd2, 32'h140, 3'b011, 1, 8'd1));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b1, 0, 1, 2'd2, 32'h140, 3'b001, 1, 8'd2));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b1, 0, 1, 2'd0, 32'h100, 3'b001, 0, 8'd2));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 0, 1, 2'd0, 32'h100, 3'b001, 0, 8'd2));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 1, 0, 2'd1, 32'h120, 3'b001, 1, 8'd2));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 0, 1, 2'd1, 32'h120, 3'b000, 1, 8'd3));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b1, 0, 1, 2'd0, 32'h100, 3'b000, 0, 8'd3));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b0, 0, 1, 2'd0, 32'h100, 3'b000, 0, 8'd3));
    tbl.push_back(mk(3'b000, 4'h0, 1'b0, 1'b1, 0, 1, 2'd0, 32'h100, 3'b000, 0, 8'd3));

    foreach (tbl[i]) begin
      set_in(tbl[i].irq, 1'b1, tbl[i].inm, tbl[i].hold, tbl[i].eret);
      tick();
      chk_obs($sformatf("row%0d", i), snap(), tbl[i].exp);
    end
    bus.in_eret = 1'b0;

    // Masked source pends but is not taken until unmasked.
    bus.in_INM = 4'b1000;
    bus.in_IRQ = 3'b100;
    tick();
    bus.in_IRQ = 3'b000;
    bk_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      bk_seen |= bus.out_BK;
    end
    chk("mask_no_bk", 32'(bk_seen), 32'd0);
    chk("mask_pend", 32'(bus.out_PEND), 32'(3'b100));
    bus.in_INM = 4'h0;
    tick();
    chk("unmask_bk", 32'(bus.out_BK), 32'd1);
    chk("unmask_code", 32'(bus.out_code), 32'd3);
    chk("unmask_vec", bus.out_VEC, 32'h160);
    finish_service();

    // Global enable low blocks taking.
    bus.in_IE = 1'b0;
    bus.in_IRQ = 3'b001;
    tick();
    bus.in_IRQ = 3'b000;
    bk_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bk_seen |= bus.out_BK;
    end
    chk("ie0_no_bk", 32'(bk_seen), 32'd0);
    chk("ie0_pend", 32'(bus.out_PEND), 32'(3'b001));
    bus.in_IE = 1'b1;
    tick();
    chk("ie1_bk", 32'(bus.out_BK), 32'd1);
    chk("ie1_code", 32'(bus.out_code), 32'd1);
    chk("ie1_nie", 32'(bus.out_NIE), 32'd0);
    finish_service();

    // Hold for 5 cycles, then a new edge on the taken source during its ACK.
    bus.in_HOLD = 1'b1;
    bus.in_IRQ = 3'b010;
    tick();
    bus.in_IRQ = 3'b000;
    bk_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bk_seen |= bus.out_BK;
    end
    chk("hold_no_bk", 32'(bk_seen), 32'd0);
    chk("hold_pend", 32'(bus.out_PEND), 32'(3'b010));
    bus.in_HOLD = 1'b0;
    tick();
    chk("hold_rel_bk", 32'(bus.out_BK), 32'd1);
    chk("hold_rel_code", 32'(bus.out_code), 32'd2);
    bus.in_IRQ = 3'b010;
    tick();
    bus.in_IRQ = 3'b000;
    chk("simul_pend", 32'(bus.out_PEND), 32'(3'b010));
    chk("simul_cnt", 32'(bus.out_CNT), 32'd6);
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    tick();
    tick();
    chk("simul_retake_bk", 32'(bus.out_BK), 32'd1);
    chk("simul_retake_code", 32'(bus.out_code), 32'd2);
    finish_service();

    // Asynchronous reset during SERVICE, IRQ held high across release.
    bus.in_IRQ = 3'b100;
    tick();
    bus.in_IRQ = 3'b000;
    tick();
    tick();
    chk("pre_rst_busy", 32'(bus.out_BUSY), 32'd1);
    bus.in_IRQ = 3'b001;
    tick();
    chk("pre_rst_pend", 32'(bus.out_PEND), 32'(3'b001));
    #2;
    rst = 1'b1;
    bus.in_IRQ = 3'b010;
    #1;
    chk_obs("async_rst", snap(), rst_exp);
    #2;
    rst = 1'b0;
    tick();
    chk("rel_pend", 32'(bus.out_PEND), 32'(3'b010));
    chk("rel_bk", 32'(bus.out_BK), 32'd0);
    tick();
    chk("rel_take_bk", 32'(bus.out_BK), 32'd1);
    chk("rel_take_code", 32'(bus.out_code), 32'd2);
    bus.in_IRQ = 3'b000;
    finish_service();

    // Counter wrap over 256 takes.
    reset_dut();
    for (int k = 0; k < 256; k++) begin
      bus.in_IRQ = 3'b001;
      tick();
      bus.in_IRQ = 3'b000;
      tick();
      if (k == 255) chk("wrap_cnt_255", 32'(bus.out_CNT), 32'd255);
      finish_service();
    end
    chk("wrap_cnt_0", 32'(bus.out_CNT), 32'd0);

    // Randomized run against the reference model.
    reset_dut();
    model_reset();
    r_irq = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) r_irq = 3'($urandom);
      set_in(r_irq,
             $urandom_range(0, 9) != 0,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0);
      model_edge(bus.in_IRQ, bus.in_IE, bus.in_INM, bus.in_HOLD, bus.in_eret);
      tick();
      chk_obs($sformatf("rand%0d", c), snap(), model_obs());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
